// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - instruction fetch with small word queue, IF/ID register and delay-slot redirects
module fetch_queue_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jar,
    input  logic [29:0] branchtarget,
    input  logic [29:0] rega,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] delayslot,
    output logic [31:0] delayslot2,
    output logic        valid
);

    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    // Queue storage: each entry remembers the word and the word address it came from
    logic [29:0]   q_pc   [QDEPTH];
    logic [31:0]   q_word [QDEPTH];
    logic [QW-1:0] rd_ptr;
    logic [QW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic [29:0] fetch_pc;
    logic [29:0] pend_tgt;
    logic        pend;
    logic        drop;
    logic        req_q;

    logic        q_empty;
    logic        ack_fire;
    logic        push;
    logic        pop;
    logic        redirect;
    logic        flush;
    logic [29:0] head_pc;
    logic [31:0] head_word;
    logic [29:0] target;

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc;

    assign q_empty   = (count == '0);
    assign ack_fire  = req_q & imem_ack;
    assign push      = ack_fire & ~drop;
    assign pop       = ~stall & ~q_empty;
    assign redirect  = valid & ~stall & (jar | jump | branch);
    // A redirect with words already queued pops the delay slot and discards everything younger
    assign flush     = redirect & ~q_empty;
    assign head_pc   = q_pc[rd_ptr];
    assign head_word = q_word[rd_ptr];

    // Redirect target selection, jr/jalr first, then j/jal, then taken branch
    always_comb begin
        target = branchtarget;
        if (jar) begin
            target = rega;
        end else if (jump) begin
            target = {delayslot[31:28], instruction[25:0]};
        end
    end

    // Occupancy after this edge; also decides whether a new request may be issued
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Queue entry write on an accepted (non-dropped) memory response
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_word[wr_ptr] <= imem_rdata;
        end
    end

    // IF/ID register, queue pointers, fetch address, drop/pend bookkeeping and request flag
    always_ff @(posedge clock) begin
        if (reset) begin
            instruction <= '0;
            delayslot   <= '0;
            delayslot2  <= '0;
            valid       <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_pc    <= RESET_PC[31:2];
            pend_tgt    <= '0;
            pend        <= 1'b0;
            drop        <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            if (!stall) begin
                if (!q_empty) begin
                    instruction <= head_word;
                    valid       <= 1'b1;
                    delayslot   <= {head_pc + 30'd1, 2'b00};
                    delayslot2  <= {head_pc + 30'd2, 2'b00};
                end else begin
                    instruction <= '0;
                    valid       <= 1'b0;
                end
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count <= count_next;

            // A completed request moves the fetch address, to the parked target if one is waiting
            if (ack_fire) begin
                drop <= 1'b0;
                if (pend) begin
                    fetch_pc <= pend_tgt;
                    pend     <= 1'b0;
                end else begin
                    fetch_pc <= fetch_pc + 30'd1;
                end
            end

            if (redirect) begin
                if (!q_empty) begin
                    if (req_q && !imem_ack) begin
                        // In-flight word is younger than the delay slot: discard it, then go to target
                        drop     <= 1'b1;
                        pend     <= 1'b1;
                        pend_tgt <= target;
                    end else begin
                        fetch_pc <= target;
                        pend     <= 1'b0;
                    end
                end else if (push) begin
                    // The word arriving now is the delay slot; it stays queued
                    fetch_pc <= target;
                    pend     <= 1'b0;
                end else begin
                    // Delay slot not yet returned; steer after its response
                    pend     <= 1'b1;
                    pend_tgt <= target;
                end
            end

            // Keep an unacknowledged request up; otherwise issue only if a slot stays free
            req_q <= (req_q & ~imem_ack) | (count_next < QDEPTH_C);
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - randomized scoreboard bench for fetch_queue_stage
`timescale 1ns/1ps
module tb_fetch_queue_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        jar;
    logic [29:0] branchtarget;
    logic [29:0] rega;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] delayslot;
    logic [31:0] delayslot2;
    logic        valid;

    fetch_queue_stage #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch(branch), .jump(jump), .jar(jar),
        .branchtarget(branchtarget), .rega(rega),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .delayslot(delayslot),
        .delayslot2(delayslot2), .valid(valid)
    );

    int checks = 0;
    int errors = 0;

    // memory model state
    int          lat_max = 0;
    int          lat_fixed = -1;
    int          wait_cnt = 0;
    logic        busy = 1'b0;
    logic [29:0] mem_addr = '0;

    // reference model state
    logic [31:0] next_pc = RESET_PC;
    logic [31:0] exp_pc_cur = '0;
    logic [31:0] exp_instr = '0;
    logic [31:0] exp_ds = '0;
    logic [31:0] exp_ds2 = '0;
    logic        exp_valid = 1'b0;
    logic        cur_is_ds = 1'b0;
    logic [31:0] tgt_q [$];
    logic        tput_mode = 1'b0;
    int          bubbles = 0;
    int          nloaded = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] t;
        t = {2'b00, a} * 32'h9E37_79B1;
        return t ^ 32'h1234_5678;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // instruction memory with random response latency; ack may come in the request cycle
    always @(negedge clock) begin
        if (reset) begin
            busy     = 1'b0;
            imem_ack = 1'b0;
        end else begin
            imem_ack = 1'b0;
            if (imem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    mem_addr = imem_addr;
                    if (lat_fixed >= 0) wait_cnt = lat_fixed;
                    else wait_cnt = (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
                end else begin
                    check("addr_stable", {2'b00, imem_addr}, {2'b00, mem_addr});
                end
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(mem_addr);
                    busy       = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // monitor: every new IF/ID instruction must be the next one in program order
    always @(posedge clock) begin
        logic st;
        logic rs;
        st = stall;
        rs = reset;
        #1;
        if (rs) begin
            next_pc   = RESET_PC;
            tgt_q.delete();
            cur_is_ds = 1'b0;
            exp_instr = '0;
            exp_valid = 1'b0;
            exp_ds    = '0;
            exp_ds2   = '0;
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_addr", {2'b00, imem_addr}, {2'b00, RESET_PC[31:2]});
        end else if (!st) begin
            if (valid) begin
                exp_pc_cur = next_pc;
                exp_instr  = mem_word(next_pc[31:2]);
                exp_valid  = 1'b1;
                exp_ds     = next_pc + 32'd4;
                exp_ds2    = next_pc + 32'd8;
                nloaded++;
                if (tgt_q.size() > 0) begin
                    next_pc   = tgt_q.pop_front();
                    cur_is_ds = 1'b1;
                end else begin
                    next_pc   = next_pc + 32'd4;
                    cur_is_ds = 1'b0;
                end
            end else begin
                exp_instr = '0;
                exp_valid = 1'b0;
                if (tput_mode) bubbles++;
            end
        end
        check("valid", 32'(valid), 32'(exp_valid));
        check("instruction", instruction, exp_instr);
        check("delayslot", delayslot, exp_ds);
        check("delayslot2", delayslot2, exp_ds2);
    end

    task automatic drive_random();
        int t;
        logic [31:0] ins;
        logic [31:0] ds;
        logic [31:0] tgt;
        stall  = ($urandom_range(3, 0) == 0);
        branch = 1'b0;
        jump   = 1'b0;
        jar    = 1'b0;
        branchtarget = 30'($urandom);
        rega         = 30'($urandom);
        if (!stall && valid) begin
            if (tgt_q.size() == 0 && !cur_is_ds && $urandom_range(7, 0) == 0) begin
                t    = int'($urandom_range(2, 0));
                jar    = (t == 0);
                jump   = (t == 1) || (t == 0 && $urandom_range(1, 0) == 1);
                branch = (t == 2) || (t < 2 && $urandom_range(1, 0) == 1);
                ins  = mem_word(exp_pc_cur[31:2]);
                ds   = exp_pc_cur + 32'd4;
                if (jar) tgt = {rega, 2'b00};
                else if (jump) tgt = {ds[31:28], ins[25:0], 2'b00};
                else tgt = {branchtarget, 2'b00};
                tgt_q.push_back(tgt);
            end
        end else if ($urandom_range(3, 0) == 0) begin
            branch = $urandom_range(1, 0) == 1;
            jump   = $urandom_range(1, 0) == 1;
            jar    = $urandom_range(1, 0) == 1;
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        stall = 1'b0;
        branch = 1'b0;
        jump = 1'b0;
        jar = 1'b0;
        branchtarget = '0;
        rega = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #2;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", {2'b00, imem_addr}, {2'b00, RESET_PC[31:2]});

        // zero-wait streaming must deliver one instruction per cycle
        repeat (6) @(negedge clock);
        tput_mode = 1'b1;
        repeat (30) @(negedge clock);
        tput_mode = 1'b0;
        check("throughput_bubbles", 32'(bubbles), 32'd0);

        // decode hold fills the queue and stops requests
        stall = 1'b1;
        repeat (5) @(negedge clock);
        check("full_req_low", 32'(imem_req), 32'd0);
        stall = 1'b0;

        lat_max = 3;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            drive_random();
        end
        @(negedge clock);
        stall = 1'b0; branch = 1'b0; jump = 1'b0; jar = 1'b0;

        // reset while a slow request is in flight
        lat_fixed = 3;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clock);
            #1;
            if (imem_req && busy && wait_cnt > 0) found = 1'b1;
        end
        check("midreq_found", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        lat_fixed = -1;
        @(posedge clock);
        #2;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", {2'b00, imem_addr}, {2'b00, RESET_PC[31:2]});
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            drive_random();
        end
        @(negedge clock);
        stall = 1'b0; branch = 1'b0; jump = 1'b0; jar = 1'b0;
        repeat (4) @(negedge clock);
        check("progress", 32'(nloaded > 800), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Instruction fetch stage that sits directly upstream of register decode. It issues word fetches to instruction memory over a request/acknowledge handshake and buffers returned words in a small queue. It drives the IF/ID pipeline register (instruction, PC+4, PC+8), honours decode stall, and applies branch, jump and jump-register redirects with MIPS single-delay-slot semantics.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] must be 0
- QDEPTH, 2, instruction queue depth; power of 2, at least 2

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- stall  in  1  decode hold; the IF/ID register keeps its value
- branch  in  1  taken branch for the instruction now in IF/ID
- jump  in  1  j/jal for the instruction now in IF/ID
- jar  in  1  jr/jalr for the instruction now in IF/ID
- branchtarget  in  30  branch target word address
- rega  in  30  jump-register target word address (busA[31:2])
- imem_req  out  1  fetch request
- imem_addr  out  30  fetch word address
- imem_ack  in  1  data valid, request complete
- imem_rdata  in  32  fetched word
- instruction  out  32  IF/ID instruction
- delayslot  out  32  IF/ID PC+4
- delayslot2  out  32  IF/ID PC+8 (link address)
- valid  out  1  IF/ID holds a real instruction

## Operation
- State:
  - fetch_pc (30b)
  - queue of {pc, word}, QDEPTH entries, plus a count
  - drop flag
  - pend flag with pend_tgt (30b)
  - IF/ID register
- Issue: imem_req=1 when count + imem_req_outstanding < QDEPTH.
  - At most one request is outstanding.
  - imem_addr=fetch_pc. Address is held stable until imem_ack.
- Ack:
  - If drop=1, the word is discarded and drop is cleared.
  - Otherwise {fetch_pc, imem_rdata} is pushed.
  - fetch_pc then advances:
    - pend=1: fetch_pc<=pend_tgt and pend is cleared.
    - Otherwise: fetch_pc<=fetch_pc+1 (mod 2^30).
- IF/ID advance when stall=0:
  - Queue non-empty: pop the head into IF/ID, set valid=1, delayslot={pc+1,2'b00}, delayslot2={pc+2,2'b00}.
  - Queue empty: insert a bubble (instruction=0, valid=0). delayslot and delayslot2 hold.
  - Push and pop in the same cycle are legal and leave count unchanged.
- Redirect is taken when valid & ~stall & (jar|jump|branch).
  - Target priority: jar→rega; jump→{delayslot[31:28],instruction[25:0]}; branch→branchtarget.
  - The delay-slot instruction (PC+4 of IF/ID) always survives. All younger instructions are killed.
  - Queue non-empty: the head (the delay slot) advances into IF/ID this edge, and all other entries are flushed.
    - If a request is outstanding with no ack this cycle, set drop=1.
    - Otherwise fetch_pc<=target.
  - Queue empty: the next accepted word is the delay slot. Set pend=1, pend_tgt=target.
- A redirect and an ack in the same cycle are resolved against the post-ack queue contents.
- Any of branch/jump/jar with valid=0 or stall=1 is ignored.

## Timing
- Reset values:
  - imem_req=0
  - imem_addr=RESET_PC[31:2]
  - instruction=0, delayslot=0, delayslot2=0, valid=0
  - queue empty; drop, pend=0
  - fetch_pc=RESET_PC[31:2]
- Reset asserted mid-request drops imem_req on the next cycle. Instruction memory must tolerate an abandoned request.
- First request: the first cycle after reset deasserts.
- With zero-wait memory (ack in the same cycle as the request), the word is in IF/ID 2 edges after the request cycle.
- Throughput: 1 instruction/cycle with zero-wait memory and stall=0.
- Redirect penalty: the target's request issues the cycle after the redirect, or the cycle after the pending ack / delay-slot ack.
- Queue full with stall=1: imem_req stays 0 until a pop occurs.

## Test plan
- Sequential fetch:
  - Stimulus: RESET_PC=0x100, zero-wait memory.
  - Required: valid IF/ID instructions from 0x100,0x104,0x108,… on consecutive cycles; delayslot=0x104, delayslot2=0x108 for the first.
- Stall and backpressure:
  - Stimulus: stall=1 for 5 cycles.
  - Required: IF/ID constant; queue fills to QDEPTH; imem_req=0 until release; no instruction lost or duplicated.
- Branch with full queue and request in flight:
  - Stimulus: branch in IF/ID at 0x200, target 0x400, 3-cycle memory latency.
  - Required: next valid instructions 0x204, then 0x400; the in-flight 0x20C response is dropped.
- Jump-register with empty queue:
  - Stimulus: jar with rega=0x300>>2, 4-cycle memory latency.
  - Required: the delay slot is fetched, then imem_addr=0x300>>2; sequence 0x…+4, 0x300.
- j target:
  - Stimulus: jump with instruction[25:0]=0x40, delayslot=0x1000_0008.
  - Required: target word address 0x1000_0100>>2.
- Reset mid-request:
  - Stimulus: reset asserted while a 3-cycle request is pending.
  - Required: all outputs at reset values next cycle; first post-reset request addr=RESET_PC>>2.
